scope_period_gen: RTL and testbench

SCOPE_PERIOD_GEN -- requirements
Module: scope_period_gen

---
 rtl/scope_period_pkg.sv | 26 ++
 rtl/scope_period_chan.sv | 99 +++++++++
 rtl/scope_period_gen.sv | 99 +++++++++
 tb/tb_scope_period_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_period_pkg.sv
// Shared definitions for the scope period generator: register offsets,
// control/status bit positions and the address-width helper.
package scope_period_pkg;

    typedef enum logic [1:0] {
        REG_PERIOD = 2'd0,
        REG_CTRL   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int unsigned REG_OFFSET_BITS   = 32'd2;
    localparam int unsigned CTRL_EN_BIT       = 32'd0;
    localparam int unsigned CTRL_ONESHOT_BIT  = 32'd1;
    localparam int unsigned STATUS_TICKED_BIT = 32'd0;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 32'd0;
        while ((32'd1 << r) < n) begin
            r = r + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scope_period_chan.sv
// One period channel: shadow/active period, down-counter, enable/one-shot
// control and the sticky TICKED flag.
module scope_period_chan
    import scope_period_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned RESET_PERIOD = 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_period,
    input  logic             wr_ctrl,
    input  logic             wr_status,
    input  logic [WIDTH-1:0] wr_data,
    output logic             tick,
    output logic             en,
    output logic             oneshot,
    output logic             ticked,
    output logic [WIDTH-1:0] shadow,
    output logic [WIDTH-1:0] active,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic             en_q,      en_d;
    logic             oneshot_q, oneshot_d;
    logic             ticked_q,  ticked_d;

    logic             tick_s;
    logic             en_req_s;
    logic             os_req_s;
    logic [WIDTH-1:0] reload_cnt_s;

    assign tick_s       = en_q & (count_q == CNT_ZERO);
    assign en_req_s     = wr_ctrl ? wr_data[CTRL_EN_BIT]      : en_q;
    assign os_req_s     = wr_ctrl ? wr_data[CTRL_ONESHOT_BIT] : oneshot_q;
    // A zero period behaves as one: the channel ticks every cycle.
    assign reload_cnt_s = (shadow_q == CNT_ZERO) ? CNT_ZERO : (shadow_q - CNT_ONE);

    // Next-state: load on enable or on a tick that is allowed to reload, else count down.
    always_comb begin
        shadow_d  = wr_period ? wr_data : shadow_q;
        active_d  = active_q;
        count_d   = count_q;
        en_d      = en_req_s;
        oneshot_d = os_req_s;
        ticked_d  = tick_s | (ticked_q & ~(wr_status & wr_data[STATUS_TICKED_BIT]));
        if (!en_q) begin
            if (en_req_s) begin
                active_d = shadow_q;
                count_d  = reload_cnt_s;
            end else begin
                count_d  = count_q;
            end
        end else if (tick_s) begin
            if (en_req_s && !os_req_s) begin
                active_d = shadow_q;
                count_d  = reload_cnt_s;
            end else begin
                en_d     = 1'b0;
            end
        end else begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q  <= WIDTH'(RESET_PERIOD);
            active_q  <= WIDTH'(RESET_PERIOD);
            count_q   <= CNT_ZERO;
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            ticked_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            count_q   <= count_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            ticked_q  <= ticked_d;
        end
    end

    assign tick    = tick_s;
    assign en      = en_q;
    assign oneshot = oneshot_q;
    assign ticked  = ticked_q;
    assign shadow  = shadow_q;
    assign active  = active_q;
    assign count   = count_q;

endmodule

// File: rtl/scope_period_gen.sv
// Multi-channel period/tick generator behind an Avalon-MM slave; this level
// only decodes the {channel, reg} address and muxes the read data.
module scope_period_gen
    import scope_period_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned RESET_PERIOD = 32'd1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [clog2(NUM_CH)+1:0]   address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic [NUM_CH-1:0]          tick,
    output logic [NUM_CH*WIDTH-1:0]    period_out
);

    logic              wr_en_s;
    logic [31:0]       chan_idx_s;
    reg_sel_e          reg_sel_s;
    logic [NUM_CH-1:0] wr_period_s;
    logic [NUM_CH-1:0] wr_ctrl_s;
    logic [NUM_CH-1:0] wr_status_s;
    logic [31:0]       chan_rd_s [NUM_CH];
    logic              unused_wdata_s;

    assign wr_en_s        = chipselect & ~write_n;
    assign chan_idx_s     = 32'(address >> REG_OFFSET_BITS);
    assign reg_sel_s      = reg_sel_e'(address[1:0]);
    assign unused_wdata_s = ^writedata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        logic             sel_s;
        logic             en_s;
        logic             oneshot_s;
        logic             ticked_s;
        logic [WIDTH-1:0] shadow_s;
        logic [WIDTH-1:0] count_s;
        logic [31:0]      rd_word_s;

        // Channel indices beyond NUM_CH never match, so their writes drop and reads return 0.
        assign sel_s          = (chan_idx_s == 32'(c));
        assign wr_period_s[c] = wr_en_s & sel_s & (reg_sel_s == REG_PERIOD);
        assign wr_ctrl_s[c]   = wr_en_s & sel_s & (reg_sel_s == REG_CTRL);
        assign wr_status_s[c] = wr_en_s & sel_s & (reg_sel_s == REG_STATUS);

        scope_period_chan #(
            .WIDTH        (WIDTH),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .wr_period (wr_period_s[c]),
            .wr_ctrl   (wr_ctrl_s[c]),
            .wr_status (wr_status_s[c]),
            .wr_data   (writedata[WIDTH-1:0]),
            .tick      (tick[c]),
            .en        (en_s),
            .oneshot   (oneshot_s),
            .ticked    (ticked_s),
            .shadow    (shadow_s),
            .active    (period_out[c*WIDTH +: WIDTH]),
            .count     (count_s)
        );

        // Per-channel read word, zero unless this channel is addressed.
        always_comb begin
            rd_word_s = 32'd0;
            if (sel_s) begin
                case (reg_sel_s)
                    REG_PERIOD: rd_word_s = 32'(shadow_s);
                    REG_CTRL: begin
                        rd_word_s[CTRL_EN_BIT]      = en_s;
                        rd_word_s[CTRL_ONESHOT_BIT] = oneshot_s;
                    end
                    REG_COUNT:  rd_word_s = 32'(count_s);
                    REG_STATUS: rd_word_s[STATUS_TICKED_BIT] = ticked_s;
                    default:    rd_word_s = 32'd0;
                endcase
            end else begin
                rd_word_s = 32'd0;
            end
        end

        assign chan_rd_s[c] = rd_word_s;
    end

    // Zero-wait-state read: OR of the one-hot per-channel words.
    always_comb begin
        readdata = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            readdata = readdata | chan_rd_s[c];
        end
    end

endmodule

// File: tb/tb_scope_period_gen.sv
// Self-checking bench for scope_period_gen: directed scenarios plus a
// randomized run against a deadline-based reference model.
`timescale 1ns/1ps
module tb_scope_period_gen;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 16;
    localparam int AW     = 4;
    localparam logic [31:0] WMASK = 32'h0000_FFFF;

    logic                    clk;
    logic                    reset;
    logic [AW-1:0]           address;
    logic                    chipselect;
    logic                    write_n;
    logic [31:0]             writedata;
    logic [31:0]             readdata;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH*WIDTH-1:0] period_out;

    int n_cmp;
    int n_err;

    // Reference model: a running channel is described by the absolute cycle of its next tick.
    logic [31:0] m_sh  [NUM_CH];
    logic [31:0] m_act [NUM_CH];
    bit          m_en  [NUM_CH];
    bit          m_os  [NUM_CH];
    bit          m_tk  [NUM_CH];
    int          m_dl  [NUM_CH];
    int          m_fz  [NUM_CH];
    int          cyc;

    scope_period_gen #(
        .NUM_CH       (NUM_CH),
        .WIDTH        (WIDTH),
        .RESET_PERIOD (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .tick       (tick),
        .period_out (period_out)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_sh[c] = 32'd1; m_act[c] = 32'd1;
            m_en[c] = 1'b0;  m_os[c] = 1'b0; m_tk[c] = 1'b0;
            m_dl[c] = 0;     m_fz[c] = 0;
        end
    endfunction

    function automatic bit m_tick(int c);
        return m_en[c] && (m_dl[c] == cyc);
    endfunction

    function automatic int m_count(int c);
        return m_en[c] ? (m_dl[c] - cyc) : m_fz[c];
    endfunction

    function automatic void m_start(int c);
        int eff;
        eff = (m_sh[c] == 32'd0) ? 1 : int'(m_sh[c]);
        m_act[c] = m_sh[c];
        m_dl[c]  = cyc + eff;
        m_en[c]  = 1'b1;
    endfunction

    function automatic void model_edge(bit wr, int ch, int r, logic [31:0] d);
        for (int c = 0; c < NUM_CH; c++) begin
            bit hit, ticking, en_req, os_req;
            hit     = wr && (ch == c);
            ticking = m_tick(c);
            en_req  = (hit && r == 1) ? d[0] : m_en[c];
            os_req  = (hit && r == 1) ? d[1] : m_os[c];
            if (ticking) m_tk[c] = 1'b1;
            else if (hit && r == 3 && d[0]) m_tk[c] = 1'b0;
            if (!m_en[c]) begin
                if (en_req) m_start(c);
            end else if (ticking) begin
                if (en_req && !os_req) m_start(c);
                else begin m_en[c] = 1'b0; m_fz[c] = 0; end
            end else if (!en_req) begin
                m_fz[c] = m_count(c) - 1;
                m_en[c] = 1'b0;
            end
            m_os[c] = os_req;
            if (hit && r == 0) m_sh[c] = d & WMASK;
        end
        cyc++;
    endfunction

    function automatic logic [31:0] m_rd(int ch, int r);
        if (ch >= NUM_CH) return 32'd0;
        case (r)
            0:       return m_sh[ch];
            1:       return {30'd0, m_os[ch], m_en[ch]};
            2:       return 32'(m_count(ch));
            default: return {31'd0, m_tk[ch]};
        endcase
    endfunction

    task automatic cycle(input logic cs, input logic wn, input int ch, input int r, input logic [31:0] d);
        address = 4'(ch * 4 + r); chipselect = cs; write_n = wn; writedata = d;
        @(posedge clk);
        model_edge(cs && !wn, ch, r, d);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        cycle(1'b1, 1'b0, ch, r, d);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, 0, 0, 32'd0);
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] v);
        address = 4'(ch * 4 + r);
        #1;
        v = readdata;
    endtask

    task automatic do_reset();
        chipselect = 1'b0; write_n = 1'b1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] v, e;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(c, r, v);
                e = (r == 0 && c < NUM_CH) ? 32'd1 : 32'd0;
                n_cmp++;
                if (v !== e) begin n_err++; $display("FAIL reset_rd ch%0d r%0d: got %0h expected %0h", c, r, v, e); end
            end
        end
        n_cmp++;
        if (tick !== 3'b000) begin n_err++; $display("FAIL reset_tick: got %b expected 000", tick); end
        n_cmp++;
        if (period_out !== 48'h0001_0001_0001) begin n_err++; $display("FAIL reset_period_out: got %h expected 000100010001", period_out); end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        int e;
        wr(0, 0, 32'd5);
        wr(0, 1, 32'd1);
        for (int k = 0; k < 15; k++) begin
            e = 4 - (k % 5);
            rd(0, 2, v);
            n_cmp++;
            if (v !== 32'(e)) begin n_err++; $display("FAIL basic_count k%0d: got %0d expected %0d", k, v, e); end
            n_cmp++;
            if (tick[0] !== (e == 0)) begin n_err++; $display("FAIL basic_tick k%0d: got %b expected %b", k, tick[0], e == 0); end
            idle();
        end
    endtask

    task automatic test_period_change();
        logic [31:0] v;
        int e, p;
        wr(0, 1, 32'd0);
        wr(0, 0, 32'd5);
        wr(0, 1, 32'd1);
        for (int k = 0; k < 14; k++) begin
            e = (k <= 4) ? 4 - k : 2 - ((k - 5) % 3);
            p = (k <= 4) ? 5 : 3;
            rd(0, 2, v);
            n_cmp++;
            if (v !== 32'(e)) begin n_err++; $display("FAIL chg_count k%0d: got %0d expected %0d", k, v, e); end
            n_cmp++;
            if (tick[0] !== (e == 0)) begin n_err++; $display("FAIL chg_tick k%0d: got %b expected %b", k, tick[0], e == 0); end
            n_cmp++;
            if (period_out[15:0] !== 16'(p)) begin n_err++; $display("FAIL chg_period_out k%0d: got %0d expected %0d", k, period_out[15:0], p); end
            if (k == 3) begin
                rd(0, 0, v);
                n_cmp++;
                if (v !== 32'd3) begin n_err++; $display("FAIL chg_shadow: got %0d expected 3", v); end
            end
            if (k == 2) wr(0, 0, 32'd3);
            else idle();
        end
    endtask

    task automatic test_zero_oneshot();
        logic [31:0] v;
        wr(0, 1, 32'd0);
        wr(0, 0, 32'd0);
        wr(0, 1, 32'd1);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (tick[0] !== 1'b1) begin n_err++; $display("FAIL zero_tick k%0d: got %b expected 1", k, tick[0]); end
            idle();
        end
        wr(0, 1, 32'd0);
        n_cmp++;
        if (tick[0] !== 1'b0) begin n_err++; $display("FAIL zero_stop: got %b expected 0", tick[0]); end
        wr(0, 0, 32'd4);
        wr(0, 1, 32'd3);
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (tick[0] !== (k == 3)) begin n_err++; $display("FAIL oneshot_tick k%0d: got %b expected %b", k, tick[0], k == 3); end
            idle();
        end
        rd(0, 1, v);
        n_cmp++;
        if (v !== 32'd2) begin n_err++; $display("FAIL oneshot_ctrl: got %0h expected 2", v); end
    endtask

    task automatic test_status_w1c();
        logic [31:0] v;
        wr(0, 0, 32'd4);
        wr(0, 1, 32'd1);
        wr(0, 3, 32'd1);
        rd(0, 3, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL w1c_clear: got %0h expected 0", v); end
        idle();
        idle();
        n_cmp++;
        if (tick[0] !== 1'b1) begin n_err++; $display("FAIL w1c_tick: got %b expected 1", tick[0]); end
        wr(0, 3, 32'd1);
        rd(0, 3, v);
        n_cmp++;
        if (v !== 32'd1) begin n_err++; $display("FAIL w1c_set_wins: got %0h expected 1", v); end
        wr(0, 3, 32'd1);
        rd(0, 3, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL w1c_second: got %0h expected 0", v); end
        wr(0, 1, 32'd0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v, e;
        int j, r;
        wr(1, 0, 32'd7);
        wr(1, 1, 32'd1);
        j = 0;
        for (int s = 1; s <= 13; s++) begin
            r = $urandom_range(0, 3);
            if (s <= 8) wr(0, r, $urandom());
            else if (s == 9) wr(0, 1, 32'd0);
            else if (s == 10) wr(0, 0, 32'd5);
            else if (s == 11) wr(0, 1, 32'd1);
            else idle();
            j++;
            rd(1, 2, v);
            n_cmp++;
            if (v !== 32'(6 - (j % 7))) begin n_err++; $display("FAIL iso_count j%0d: got %0d expected %0d", j, v, 6 - (j % 7)); end
            n_cmp++;
            if (tick[1] !== ((j % 7) == 6)) begin n_err++; $display("FAIL iso_tick j%0d: got %b expected %b", j, tick[1], (j % 7) == 6); end
            n_cmp++;
            if (period_out[31:16] !== 16'd7) begin n_err++; $display("FAIL iso_period_out j%0d: got %0d expected 7", j, period_out[31:16]); end
        end
        rd(0, 2, v);
        n_cmp++;
        if (v !== 32'd2) begin n_err++; $display("FAIL pre_reset_count: got %0d expected 2", v); end
        #5 reset = 1'b1;
        #1;
        n_cmp++;
        if (tick !== 3'b000) begin n_err++; $display("FAIL mid_reset_tick: got %b expected 000", tick); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (tick !== 3'b000) begin n_err++; $display("FAIL held_reset_tick k%0d: got %b expected 000", k, tick); end
        end
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                rd(c, rr, v);
                e = (rr == 0) ? 32'd1 : 32'd0;
                n_cmp++;
                if (v !== e) begin n_err++; $display("FAIL post_reset_rd ch%0d r%0d: got %0h expected %0h", c, rr, v, e); end
            end
        end
        n_cmp++;
        if (period_out !== 48'h0001_0001_0001) begin n_err++; $display("FAIL post_reset_period_out: got %h expected 000100010001", period_out); end
    endtask

    task automatic test_random();
        logic [31:0] v, e, d;
        logic [NUM_CH-1:0] et;
        logic [NUM_CH*WIDTH-1:0] ep;
        int kind, ch, r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 9);
            ch   = $urandom_range(0, 3);
            r    = $urandom_range(0, 3);
            if (r == 0) d = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            else if (r == 1) d = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
            else d = $urandom();
            if (kind < 4) cycle(1'b1, 1'b0, ch, r, d);
            else if (kind == 4) cycle(1'b1, 1'b1, ch, r, d);
            else if (kind == 5) cycle(1'b0, 1'b0, ch, r, d);
            else idle();
            for (int c = 0; c < NUM_CH; c++) begin
                et[c] = m_tick(c);
                ep[c*WIDTH +: WIDTH] = m_act[c][WIDTH-1:0];
            end
            n_cmp++;
            if (tick !== et) begin n_err++; $display("FAIL rnd_tick i%0d: got %b expected %b", i, tick, et); end
            n_cmp++;
            if (period_out !== ep) begin n_err++; $display("FAIL rnd_period_out i%0d: got %h expected %h", i, period_out, ep); end
            for (int c = 0; c < 4; c++) begin
                for (int rr = 0; rr < 4; rr++) begin
                    rd(c, rr, v);
                    e = m_rd(c, rr);
                    n_cmp++;
                    if (v !== e) begin n_err++; $display("FAIL rnd_rd i%0d ch%0d r%0d: got %0h expected %0h", i, c, rr, v, e); end
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 4'd0; writedata = 32'd0;
        model_reset();
        test_reset();
        test_basic();
        test_period_change();
        test_zero_oneshot();
        test_status_w1c();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
